// File: rtl/pwm_capture_pkg.sv
// pwm_capture_pkg: shared types and defaults for the PWM capture block.
package pwm_capture_pkg;
  localparam int WIDTH_DEFAULT = 8;
  localparam int SYNC_STAGES_DEFAULT = 2;
  typedef enum logic {IDLE, MEASURE} state_t;
  function automatic logic [31:0] cnt_max(input int w);
    return (32'd1 << w) - 32'd1;
  endfunction
endpackage

// File: rtl/pwm_capture_if.sv
// pwm_capture_if: PWM input and measurement results of pwm_capture.
interface pwm_capture_if
  import pwm_capture_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
);
  logic             pwm_in;
  logic [WIDTH-1:0] period;
  logic [WIDTH-1:0] high_t;
  logic             valid;
  logic             locked;
  modport master(output pwm_in, input period, high_t, valid, locked);
  modport slave(input pwm_in, output period, high_t, valid, locked);
endinterface

// File: rtl/pwm_edge_sync.sv
// pwm_edge_sync: synchronizer, optional glitch filter (PWM_CAPTURE_GLITCH_FILTER_EN), edge detector.
module pwm_edge_sync
  import pwm_capture_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pwm_in,
  output logic level,
  output logic rise_det,
  output logic fall_det
);
  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync <= '0;
    else sync <= {sync[SYNC_STAGES-2:0], pwm_in};
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  logic filt, pend;
  // level follows sync only after two consecutive differing samples
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      filt <= 1'b0;
      pend <= 1'b0;
    end else begin
      pend <= (sync[SYNC_STAGES-1] != filt) && !pend;
      if (pend && sync[SYNC_STAGES-1] != filt) filt <= sync[SYNC_STAGES-1];
    end
  assign level = filt;
`else
  assign level = sync[SYNC_STAGES-1];
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) prev <= 1'b0;
    else prev <= level;
  assign rise_det = level & ~prev;
  assign fall_det = ~level & prev;
endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: measures PWM period and high time in clk cycles, one-cycle valid per result.
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEFAULT,
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input logic          clk,
  input logic          rst_n,
  pwm_capture_if.slave bus
);
  localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(cnt_max(WIDTH));
  state_t           state, state_n;
  logic [WIDTH-1:0] cnt, hi_lat;
  logic             level, rise_det, fall_det, report;
  pwm_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk,
    .rst_n,
    .pwm_in(bus.pwm_in),
    .level,
    .rise_det,
    .fall_det
  );
  assert property (@(posedge clk) disable iff (!rst_n)
    !(rise_det && fall_det) && (!rise_det || level));
  // rise_det wins over saturation, so a full-scale period is still reported
  always_comb begin
    state_n = rise_det ? MEASURE : (state == MEASURE && cnt == CNT_MAX) ? IDLE : state;
  end
  assign report = rise_det && state == MEASURE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt        <= '0;
      hi_lat     <= '0;
      bus.period <= '0;
      bus.high_t <= '0;
      bus.valid  <= 1'b0;
    end else begin
      cnt       <= rise_det ? WIDTH'(1) : (cnt == CNT_MAX ? cnt : cnt + 1'b1);
      bus.valid <= report;
      if (state == MEASURE && fall_det) hi_lat <= cnt;
      if (report) begin
        bus.period <= cnt;
        bus.high_t <= hi_lat;
      end
    end
  assign bus.locked = state == MEASURE;
endmodule
